// File: rtl/bus_pkg.sv
// Shared types and constants for the serial master/slave bus.
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        RESP
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/master_port_if.sv
// Serial bus between a master port and a slave port.
//
// Handshake: a wr_bus bit moves on every posedge where master_valid && slave_ready;
// an rd_bus bit moves on every posedge where slave_valid && master_ready. A sender
// holds its data stable while valid is high and ready is low.
interface master_port_if;

    logic mode;
    logic wr_bus;
    logic master_valid;
    logic master_ready;
    logic rd_bus;
    logic slave_ready;
    logic slave_valid;

    modport master (
        output mode,
        output wr_bus,
        output master_valid,
        output master_ready,
        input  rd_bus,
        input  slave_ready,
        input  slave_valid
    );

    modport slave (
        input  mode,
        input  wr_bus,
        input  master_valid,
        input  master_ready,
        output rd_bus,
        output slave_ready,
        output slave_valid
    );

endinterface

// File: rtl/serial_shift_reg.sv
// Left-shifting register: parallel load, MSB shift-out, LSB shift-in, parallel read.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_out_en,
    input  logic             shift_in_en,
    input  logic             shift_in,
    output logic             msb,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_out_en || shift_in_en) begin
            q <= {q[WIDTH-2:0], shift_in_en & shift_in};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/master_port.sv
// Bus master: serializes a parallel request onto wr_bus and, for reads,
// deserializes the rd_bus reply into a parallel response with timeout error.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    master_port_if.master         bus,
    output state_t                state_dbg
);

    localparam int TX_W    = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
    localparam int STALL_W = $clog2(max_int(TIMEOUT, 1) + 1);
    localparam logic [CNT_W-1:0]   ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(max_int(TIMEOUT, 1) - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_d;
    logic               mode_q, mode_d;
    logic               err_q, err_d;
    logic               active, xfer, master_valid, master_ready;
    logic               tx_load, tx_shift, rx_load, rx_shift, tx_msb;
    logic [TX_W-1:0]    unused_tx_q;
    logic [DATA_WIDTH-1:0] rx_q;

    serial_shift_reg #(.WIDTH(TX_W)) u_tx (
        .clk          (clk),
        .rstn         (rstn),
        .load         (tx_load),
        .load_data    ({req_addr, req_wdata}),
        .shift_out_en (tx_shift),
        .shift_in_en  (1'b0),
        .shift_in     (1'b0),
        .msb          (tx_msb),
        .q            (unused_tx_q)
    );

    // rx doubles as the response data register: cleared on accept and on timeout.
    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx (
        .clk          (clk),
        .rstn         (rstn),
        .load         (rx_load),
        .load_data    ('0),
        .shift_out_en (1'b0),
        .shift_in_en  (rx_shift),
        .shift_in     (bus.rd_bus),
        .msb          (),
        .q            (rx_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            stall_cnt <= '0;
            mode_q    <= MODE_READ;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            stall_cnt <= stall_cnt_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        stall_cnt_d  = stall_cnt;
        mode_d       = mode_q;
        err_d        = err_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;
        rx_load      = 1'b0;
        rx_shift     = 1'b0;
        active       = 1'b0;
        xfer         = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tx_load     = 1'b1;
                    rx_load     = 1'b1;
                    mode_d      = req_write;
                    err_d       = 1'b0;
                    bit_cnt_d   = '0;
                    stall_cnt_d = '0;
                    state_d     = ADDR;
                end
            end
            ADDR, WDATA: begin
                active       = 1'b1;
                master_valid = 1'b1;
                xfer         = bus.slave_ready;
                tx_shift     = bus.slave_ready;
                if (xfer) begin
                    stall_cnt_d = '0;
                    bit_cnt_d   = bit_cnt + 1'b1;
                    if (state == ADDR && bit_cnt == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (mode_q == MODE_WRITE) ? WDATA : RDATA;
                    end else if (state == WDATA && bit_cnt == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = RESP;
                    end
                end
            end
            RDATA: begin
                active       = 1'b1;
                master_ready = 1'b1;
                xfer         = bus.slave_valid;
                rx_shift     = bus.slave_valid;
                if (xfer) begin
                    stall_cnt_d = '0;
                    bit_cnt_d   = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort drops mode so every bus output is low while the error is reported.
        if (active && !xfer && TIMEOUT != 0) begin
            if (stall_cnt == STALL_LAST) begin
                state_d     = RESP;
                err_d       = 1'b1;
                mode_d      = MODE_READ;
                rx_load     = 1'b1;
                bit_cnt_d   = '0;
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt + 1'b1;
            end
        end
    end

    assign bus.master_valid = master_valid;
    assign bus.master_ready = master_ready;
    assign bus.wr_bus       = master_valid & tx_msb;
    assign bus.mode         = mode_q;
    assign rsp_err          = err_q;
    assign rsp_rdata        = rx_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_master_port.sv
// Self-checking bench for master_port with a behavioural serial slave.
module tb_master_port;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_rdata;
    state_t      state_dbg;

    master_port_if bus_if ();

    master_port #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .TIMEOUT    (32)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    logic [8:0] rsp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge where the response handshake is set up.
    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                          input logic [7:0] sdata, input int stall_after, input int stall_len,
                          input int vdelay, input int rsp_delay, input bit hold_valid,
                          input logic exp_err, input logic [7:0] exp_rdata,
                          output int lat, output int r0, output int v0,
                          output int waits, output int addr_xfers);
        logic [23:0] pat;
        logic [7:0]  rd_sh;
        int bits_done, stalled, rd_cnt, rsp_cnt, nbits;
        bit done;
        bits_done = 0; stalled = 0; rd_cnt = 0; rsp_cnt = 0; done = 0;
        lat = -1; r0 = -1; v0 = -1; waits = 0; addr_xfers = 0;
        pat   = {addr, wdata};
        rd_sh = sdata;
        nbits = wr ? 24 : 16;
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back(pat[23]);
            pat = pat << 1;
        end
        rsp_q.push_back({exp_err, exp_rdata});

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'(1));

        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk);
            req_valid = hold_valid;
            bus_if.slave_ready = !(bits_done == stall_after && stalled < stall_len);
            if (!bus_if.slave_ready) stalled++;
            if (bus_if.master_ready && r0 < 0) r0 = cyc;
            bus_if.slave_valid = (r0 >= 0 && vdelay >= 0 && cyc - r0 >= vdelay && rd_cnt < 8);
            bus_if.rd_bus = bus_if.slave_valid & rd_sh[7];
            if (bus_if.slave_valid && v0 < 0) v0 = cyc;
            rsp_ready = (rsp_cnt >= rsp_delay);

            if (bus_if.master_valid) begin
                check("mode_tx", 32'(bus_if.mode), 32'(wr));
                if (exp_q.size() == 0) begin
                    check("extra_bit", 32'(exp_q.size()), 32'(1));
                end else begin
                    check("wr_bus", 32'(bus_if.wr_bus), 32'(exp_q[0]));
                    if (bus_if.slave_ready) begin
                        void'(exp_q.pop_front());
                        bits_done++;
                        if (bits_done <= 16) addr_xfers++;
                    end
                end
            end
            if (bus_if.master_ready) begin
                check("rd_mv_low", 32'(bus_if.master_valid), 32'(0));
                check("mode_rx", 32'(bus_if.mode), 32'(wr));
                if (bus_if.slave_valid) begin
                    rd_cnt++;
                    rd_sh = rd_sh << 1;
                end
            end
            if (rsp_valid) begin
                if (lat < 0) lat = cyc;
                check("req_ready_resp", 32'(req_ready), 32'(0));
                check("bus_idle_resp", 32'({bus_if.master_valid, bus_if.master_ready, bus_if.wr_bus}), 32'(0));
                if (exp_err) check("mode_err", 32'(bus_if.mode), 32'(0));
                if (rsp_q.size() > 0) check("rsp", 32'({rsp_err, rsp_rdata}), 32'(rsp_q[0]));
                if (rsp_ready) begin
                    void'(rsp_q.pop_front());
                    done = 1;
                end
                rsp_cnt++;
            end
        end
        if (!done) check("rsp_timeout", 32'(done), 32'(1));
        check("bits_left", exp_q.size(), 0);
        exp_q.delete();
        rsp_q.delete();
        bus_if.slave_ready = 1'b1;
        bus_if.slave_valid = 1'b0;
        bus_if.rd_bus      = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  sdata;
        logic        exp_err;
        logic [7:0]  exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, r0, v0, waits, ax;
        logic wr;
        logic [7:0] sd;
        int vd;

        vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, 8'h00, 25};
        vecs[1] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0, 8'h00, 25};
        vecs[2] = '{1'b0, 16'h8001, 8'h00, 8'hFF, 1'b0, 8'hFF, 25};
        vecs[3] = '{1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 8'h00, 25};
        vecs[4] = '{1'b1, 16'hFFFF, 8'hFF, 8'h00, 1'b0, 8'h00, 25};
        vecs[5] = '{1'b0, 16'hAAAA, 8'h00, 8'h96, 1'b0, 8'h96, 25};

        rstn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        bus_if.slave_ready = 1'b1; bus_if.slave_valid = 1'b0; bus_if.rd_bus = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_bus", 32'({bus_if.master_valid, bus_if.master_ready, bus_if.wr_bus, bus_if.mode}), 32'(0));
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'(0));
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sdata, -1, 0, 0, 0, 1'b0,
                   vecs[i].exp_err, vecs[i].exp_rdata, lat, r0, v0, waits, ax);
            check("vec_lat", lat, vecs[i].exp_lat);
        end

        for (int i = 0; i < 4; i++) begin
            wr = 1'($urandom_range(0, 1));
            sd = 8'($urandom_range(0, 255));
            vd = wr ? 0 : $urandom_range(0, 3);
            do_txn(wr, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), sd, -1, 0, vd,
                   $urandom_range(0, 3), 1'b0, 1'b0, wr ? 8'h00 : sd, lat, r0, v0, waits, ax);
            check("rand_lat", lat, 25 + vd);
        end

        // read with late slave_valid
        do_txn(1'b0, 16'h0005, 8'h00, 8'h3C, -1, 0, 3, 0, 1'b0, 1'b0, 8'h3C, lat, r0, v0, waits, ax);
        check("late_rd_lat", lat, v0 + 8);

        // slave_ready low 4 cycles once 6 address bits have moved
        do_txn(1'b1, 16'hC3A5, 8'h5A, 8'h00, 6, 4, 0, 0, 1'b0, 1'b0, 8'h00, lat, r0, v0, waits, ax);
        check("stall_addr_xfers", ax, 16);
        check("stall_lat", lat, 29);

        // read timeout: slave never answers
        do_txn(1'b0, 16'h0042, 8'h00, 8'h00, -1, 0, -1, 0, 1'b0, 1'b1, 8'h00, lat, r0, v0, waits, ax);
        check("timeout_lat", lat - r0, 32);

        // response backpressure with a request already waiting
        do_txn(1'b0, 16'h0123, 8'h00, 8'h5E, -1, 0, 0, 10, 1'b1, 1'b0, 8'h5E, lat, r0, v0, waits, ax);
        check("bp_lat", lat, 25);
        do_txn(1'b1, 16'hBEEF, 8'h11, 8'h00, -1, 0, 0, 0, 1'b0, 1'b0, 8'h00, lat, r0, v0, waits, ax);
        check("bp_next_wait", waits, 1);
        check("bp_next_lat", lat, 25);

        // reset during WDATA bit 3
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h00FF; req_wdata = 8'h5A;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("pre_rst_state", 32'(state_dbg), 32'(WDATA));
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_bus", 32'({bus_if.master_valid, bus_if.wr_bus, bus_if.mode}), 32'(0));
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_rsp", 32'({rsp_valid, bus_if.master_valid}), 32'(0));
        end
        do_txn(1'b1, 16'h0001, 8'hC3, 8'h00, -1, 0, 0, 0, 1'b0, 1'b0, 8'h00, lat, r0, v0, waits, ax);
        check("post_rst_lat", lat, 25);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
